// File: rtl/lf_pkg.sv
// Shared state/direction types, motor patterns and sensor decode for line_follow_ctrl.
package lf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_RIGHT  = 3'd2,
    ST_LEFT   = 3'd3,
    ST_DEAD   = 3'd4,
    ST_SEARCH = 3'd5
  } lf_state_e;

  typedef enum logic [1:0] {
    DIR_FWD,
    DIR_RIGHT,
    DIR_LEFT,
    DIR_LOST
  } lf_dir_e;

  // Motor bits are {A_fwd, A_rev, B_fwd, B_rev}
  localparam logic [3:0] MOT_OFF    = 4'b0000;
  localparam logic [3:0] MOT_FWD    = 4'b1010;
  localparam logic [3:0] MOT_RIGHT  = 4'b1001;
  localparam logic [3:0] MOT_LEFT   = 4'b0110;
  localparam logic [3:0] MOT_SEARCH = 4'b0110;

  // Sensor codes are {front, left, right}
  localparam logic [2:0] SENS_LOST      = 3'b111;
  localparam logic [2:0] SENS_FWD_CLEAR = 3'b000;
  localparam logic [2:0] SENS_FWD_BOTH  = 3'b011;

  function automatic lf_dir_e sens_decode(input logic [2:0] s);
    if (s == SENS_LOST) return DIR_LOST;
    if (s == SENS_FWD_CLEAR || s == SENS_FWD_BOTH) return DIR_FWD;
    if (!s[0]) return DIR_RIGHT;
    return DIR_LEFT;
  endfunction

  function automatic lf_state_e dir_state(input lf_dir_e d);
    case (d)
      DIR_FWD:   return ST_FWD;
      DIR_RIGHT: return ST_RIGHT;
      DIR_LEFT:  return ST_LEFT;
      default:   return ST_IDLE;
    endcase
  endfunction

  function automatic logic [3:0] mot_pattern(input lf_state_e s);
    case (s)
      ST_FWD:    return MOT_FWD;
      ST_RIGHT:  return MOT_RIGHT;
      ST_LEFT:   return MOT_LEFT;
      ST_SEARCH: return MOT_SEARCH;
      default:   return MOT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/lf_pwm.sv
// PWM counter (period 2^PWM_W-1), per-period duty latch and comparator.
module lf_pwm #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm
);

  localparam logic [PWM_W-1:0] CNT_MAX = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] duty_q;
  logic [PWM_W-1:0] duty_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      duty_q <= '0;
    end else if (en) begin
      if (cnt == '0) duty_q <= duty;
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  // The cnt=0 slot already compares against the duty being latched there.
  assign duty_eff = (cnt == '0) ? duty : duty_q;
  assign pwm      = (cnt < duty_eff);

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follower motor controller: sensor debounce, direction FSM with dead time, PWM gating.
// Define LF_SEARCH_EN to make the lost-line action enter SEARCH instead of IDLE.
import lf_pkg::*;

module line_follow_ctrl #(
  parameter int PWM_W    = 8,
  parameter int DEB_CYC  = 4,
  parameter int DEAD_CYC = 2,
  parameter int LOST_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [2:0]       sens,
  input  logic [PWM_W-1:0] duty,
  output logic [3:0]       mot,
  output logic [2:0]       state_o
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int DEAD_W = $clog2(DEAD_CYC + 1);
  localparam int LOST_W = $clog2(LOST_CYC + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYC);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
  localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_CYC - 1);

`ifdef LF_SEARCH_EN
  localparam lf_state_e LOST_TGT = ST_SEARCH;
`else
  localparam lf_state_e LOST_TGT = ST_IDLE;
`endif

  logic              rst_meta, rst_ok;
  logic [DEB_W-1:0]  warm_cnt;
  logic              ready;
  logic [DEB_W-1:0]  deb_cnt [3];
  logic [2:0]        filt;
  lf_dir_e           dir;
  lf_state_e         state;
  logic [DEAD_W-1:0] dead_cnt;
  logic [LOST_W-1:0] lost_cnt;
  logic              pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
      rst_ok   <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_ok   <= rst_meta;
    end
  end

  // Nothing advances until rst_ok; flops simply keep their reset values meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= '0;
      filt     <= '0;
      for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else if (rst_ok) begin
      if (!ready) warm_cnt <= warm_cnt + 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sens[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt[i]    <= sens[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // The reset-state filter value is not trusted until a full debounce window has elapsed.
  assign ready = (warm_cnt == DEB_MAX);
  assign dir   = sens_decode(filt);

  lf_pwm #(.PWM_W(PWM_W)) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (rst_ok),
    .duty (duty),
    .pwm  (pwm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dead_cnt <= '0;
      lost_cnt <= '0;
      mot      <= '0;
    end else if (rst_ok) begin
      mot      <= mot_pattern(state) & {4{pwm}};
      dead_cnt <= '0;
      lost_cnt <= '0;
      if (!run) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:
            if (ready && dir != DIR_LOST) state <= dir_state(dir);
          ST_FWD, ST_RIGHT, ST_LEFT:
            if (dir == DIR_LOST) begin
              if (lost_cnt == LOST_LAST) state <= LOST_TGT;
              else lost_cnt <= lost_cnt + 1'b1;
            end else if (dir_state(dir) != state) begin
              state <= ST_DEAD;
            end
          ST_DEAD:
            if (dead_cnt == DEAD_LAST)
              state <= (dir == DIR_LOST) ? LOST_TGT : dir_state(dir);
            else
              dead_cnt <= dead_cnt + 1'b1;
          ST_SEARCH:
            if (dir != DIR_LOST) state <= ST_DEAD;
          default:
            state <= ST_IDLE;
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Randomized self-checking bench for line_follow_ctrl against a behavioural reference model.
module tb_line_follow_ctrl;

  localparam int PWM_W = 8;
  localparam int DEB   = 4;
  localparam int DEAD  = 2;
  localparam int LOST  = 20;
  localparam int PER   = (1 << PWM_W) - 1;
`ifdef LF_SEARCH_EN
  localparam int LOST_TGT = 5;
`else
  localparam int LOST_TGT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic [2:0]       sens = 3'b000;
  logic [PWM_W-1:0] duty = '0;
  logic [3:0]       mot;
  logic [2:0]       state_o;

  line_follow_ctrl #(
    .PWM_W   (PWM_W),
    .DEB_CYC (DEB),
    .DEAD_CYC(DEAD),
    .LOST_CYC(LOST)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .sens   (sens),
    .duty   (duty),
    .mot    (mot),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: decode and pattern tables straight from the rule lists,
  // PWM phase derived from the absolute count of enabled cycles.
  int         dec_tab [8] = '{1, 3, 2, 1, 2, 3, 2, -1};
  logic [3:0] pat_tab [6] = '{4'b0000, 4'b1010, 4'b1001, 4'b0110, 4'b0000, 4'b0110};

  int         m_state, dead_left, lost_streak, rel_edges, act_n, m_duty;
  logic [3:0] m_mot;
  logic [2:0] m_filt, last_raw;
  int         runlen [3];

  task automatic model_reset();
    m_state = 0; dead_left = 0; lost_streak = 0; rel_edges = 0; act_n = 0;
    m_duty = 0; m_mot = '0; m_filt = '0; last_raw = '0;
    for (int i = 0; i < 3; i++) runlen[i] = 0;
  endtask

  task automatic model_edge();
    int d, ns, phase;
    bit p;
    if (!rst_n) return;
    rel_edges++;
    if (rel_edges < 3) return;
    phase = act_n % PER;
    if (phase == 0) m_duty = int'(duty);
    p = (phase < m_duty);
    d = dec_tab[m_filt];
    ns = m_state;
    if (!run) begin
      ns = 0;
      lost_streak = 0;
    end else begin
      case (m_state)
        0: if (act_n >= DEB && d >= 0) ns = d;
        1, 2, 3:
          if (d < 0) begin
            lost_streak++;
            if (lost_streak == LOST) begin
              ns = LOST_TGT;
              lost_streak = 0;
            end
          end else begin
            lost_streak = 0;
            if (d != m_state) begin
              ns = 4;
              dead_left = DEAD;
            end
          end
        4: begin
          dead_left--;
          if (dead_left == 0) ns = (d < 0) ? LOST_TGT : d;
        end
        5: if (d >= 0) begin
          ns = 4;
          dead_left = DEAD;
        end
        default: ns = 0;
      endcase
    end
    m_mot = p ? pat_tab[m_state] : 4'b0000;
    m_state = ns;
    for (int i = 0; i < 3; i++) begin
      if (act_n == 0 || sens[i] != last_raw[i]) runlen[i] = 1;
      else runlen[i]++;
      last_raw[i] = sens[i];
      if (sens[i] != m_filt[i] && runlen[i] >= DEB) m_filt[i] = sens[i];
    end
    act_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("state", state_o, m_state);
    check("mot", mot, m_mot);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_state", state_o, 0);
    check("rst_async_mot", mot, 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic count_on(input string tag, input int exp);
    int on;
    on = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (mot != 4'b0000) on++;
    end
    check(tag, on, exp);
  endtask

  initial begin
    model_reset();
    run = 1'b1; sens = 3'b000; duty = 8'hFF;
    @(negedge clk);
    ticks(3);
    check("rst_state", state_o, 0);
    check("rst_mot", mot, 0);
    rst_n = 1'b1;

    ticks(2 + DEB);
    check("pre_fwd", state_o, 0);
    tick();
    check("fwd_lat", state_o, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("fwd_full", mot, 4'b1010);
    end

    sens = 3'b100;
    ticks(DEB - 1);
    sens = 3'b000;
    ticks(8);
    check("glitch", state_o, 1);

    duty = 8'd64;  ticks(300); count_on("duty64", 64);
    duty = 8'd128; ticks(510); count_on("duty128", 128);
    duty = 8'd0;   ticks(300); count_on("duty0", 0);
    duty = 8'hFF;  ticks(260);

    sens = 3'b100;
    ticks(DEB + 1);
    check("dead_enter", state_o, 4);
    tick();
    check("dead_hold", state_o, 4);
    check("dead_mot", mot, 0);
    tick();
    check("dead_exit", state_o, 2);

    run = 1'b0;
    tick();
    check("run_off", state_o, 0);
    tick();
    check("run_off_mot", mot, 0);
    run = 1'b1;
    tick();
    check("reenter", state_o, 2);

    sens = 3'b111;
    ticks(DEB + LOST - 1);
    check("lost_hold", state_o, 2);
    tick();
    check("lost_act", state_o, LOST_TGT);
    sens = 3'b001;
    ticks(DEB + 1 + DEAD);
    check("lost_exit", state_o, 3);

    sens = 3'b100;
    ticks(DEB + 1);
    check("pre_rst_dead", state_o, 4);
    apply_reset();

    for (int s = 0; s < 350; s++) begin
      int unsigned r, len;
      r = $urandom_range(0, 99);
      run = (r >= 3);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       duty = '0;
          1:       duty = '1;
          default: duty = PWM_W'($urandom_range(0, PER));
        endcase
      end
      if (r >= 94) begin
        sens = 3'b111;
        len = LOST + $urandom_range(0, 10);
      end else begin
        sens = 3'($urandom_range(0, 6));
        len = $urandom_range(1, 10);
      end
      ticks(int'(len));
      if (s == 120 || s == 250) apply_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
